threshold_monitor_multi: RTL and testbench

//  Parametrised successor to the fixed dual-threshold signed comparator. Compares a stream of signed

---
 rtl/thrmon_pkg.sv | 24 ++
 rtl/thrmon_channel.sv | 116 +++++++++++
 rtl/threshold_monitor_multi.sv | 81 ++++++++
 tb/tb_threshold_monitor_multi.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/thrmon_pkg.sv
// Package for the multi-channel threshold monitor.
// Holds the per-channel FSM state type, the debounce counter width helper
// and the default parameter values shared by the top and channel modules.
package thrmon_pkg;

  typedef enum logic [1:0] {
    BELOW   = 2'd0,
    RISING  = 2'd1,
    ABOVE   = 2'd2,
    FALLING = 2'd3
  } thr_state_t;

  // Width needed to hold a count of 0..debounce.
  function automatic int unsigned cnt_w(input int unsigned debounce);
    return $clog2(debounce + 1);
  endfunction

  localparam int unsigned THRMON_DATA_W      = 32;
  localparam int unsigned THRMON_NUM_THR     = 4;
  localparam int unsigned THRMON_DEBOUNCE    = 3;
  localparam int unsigned THRMON_HYST        = 10;
  localparam int          THRMON_THR_RST_VAL = -100;

endpackage

// File: rtl/thrmon_channel.sv
// One threshold channel: programmable signed threshold register, hysteresis
// and debounce FSM, and registered over / rise / fall outputs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   sample_valid    sample_data qualified this cycle
//   sample_data     signed sample
//   wr_en, wr_data  threshold write for this channel (already decoded)
//   over            debounced "above threshold" level
//   rise_pulse      one-cycle pulse on over 0->1
//   fall_pulse      one-cycle pulse on over 1->0
module thrmon_channel
  import thrmon_pkg::*;
#(
  parameter int unsigned DATA_W      = THRMON_DATA_W,
  parameter int unsigned DEBOUNCE    = THRMON_DEBOUNCE,
  parameter int unsigned HYST        = THRMON_HYST,
  parameter int          THR_RST_VAL = THRMON_THR_RST_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              over,
  output logic              rise_pulse,
  output logic              fall_pulse
);

  localparam int unsigned CW = cnt_w(DEBOUNCE);
  localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THR_RST_VAL);

  logic signed [DATA_W-1:0] thr_q;
  thr_state_t               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic                     above, rel_hit, over_d;
  logic signed [DATA_W:0]   samp_x, rel_lvl;

  always_comb begin
    // Release level is formed one bit wider so thr - HYST cannot wrap.
    samp_x  = $signed({sample_data[DATA_W-1], sample_data});
    rel_lvl = $signed({thr_q[DATA_W-1], thr_q}) - $signed((DATA_W+1)'(HYST));
    above   = $signed(sample_data) > thr_q;
    rel_hit = samp_x <= rel_lvl;
    cnt_inc = cnt_q + CW'(1);

    state_d = state_q;
    cnt_d   = cnt_q;

    if (sample_valid) begin
      case (state_q)
        BELOW, RISING: begin
          if (above) begin
            if (cnt_inc == CW'(DEBOUNCE)) begin
              state_d = ABOVE;
              cnt_d   = '0;
            end else begin
              state_d = RISING;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = BELOW;
            cnt_d   = '0;
          end
        end
        ABOVE, FALLING: begin
          if (rel_hit) begin
            if (cnt_inc == CW'(DEBOUNCE)) begin
              state_d = BELOW;
              cnt_d   = '0;
            end else begin
              state_d = FALLING;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = ABOVE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = BELOW;
          cnt_d   = '0;
        end
      endcase
    end

    // A write is applied on top of the sample result (which used the old
    // threshold): any debounce run in progress is discarded.
    if (wr_en) begin
      cnt_d = '0;
      if (state_d == RISING)  state_d = BELOW;
      if (state_d == FALLING) state_d = ABOVE;
    end

    over_d = (state_d == ABOVE) || (state_d == FALLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q      <= THR_RST;
      state_q    <= BELOW;
      cnt_q      <= '0;
      over       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (wr_en) thr_q <= wr_data;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      over       <= over_d;
      rise_pulse <= over_d & ~over;
      fall_pulse <= ~over_d & over;
    end
  end

endmodule

// File: rtl/threshold_monitor_multi.sv
// Multi-channel signed threshold monitor with hysteresis and debounce.
// Optional min/max sample trackers are built when THRMON_MINMAX_EN is defined.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_valid          sample_data qualified this cycle
//   sample_data           signed sample
//   thr_wr_en/idx/data    threshold write; idx >= NUM_THR ignored
//   over                  per-channel debounced above level
//   rise_pulse/fall_pulse per-channel one-cycle edge pulses
//   stat_clr              clear min/max trackers (THRMON_MINMAX_EN)
//   min_seen/max_seen     signed sample extremes (THRMON_MINMAX_EN)
module threshold_monitor_multi
  import thrmon_pkg::*;
#(
  parameter int unsigned DATA_W      = THRMON_DATA_W,
  parameter int unsigned NUM_THR     = THRMON_NUM_THR,
  parameter int unsigned DEBOUNCE    = THRMON_DEBOUNCE,
  parameter int unsigned HYST        = THRMON_HYST,
  parameter int          THR_RST_VAL = THRMON_THR_RST_VAL,
  localparam int unsigned IDX_W      = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample_data,
  input  logic               thr_wr_en,
  input  logic [IDX_W-1:0]   thr_wr_idx,
  input  logic [DATA_W-1:0]  thr_wr_data,
  output logic [NUM_THR-1:0] over,
  output logic [NUM_THR-1:0] rise_pulse,
  output logic [NUM_THR-1:0] fall_pulse
`ifdef THRMON_MINMAX_EN
  ,
  input  logic               stat_clr,
  output logic [DATA_W-1:0]  min_seen,
  output logic [DATA_W-1:0]  max_seen
`endif
);

  for (genvar i = 0; i < NUM_THR; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = thr_wr_en && (thr_wr_idx == IDX_W'(i));

    thrmon_channel #(
      .DATA_W      (DATA_W),
      .DEBOUNCE    (DEBOUNCE),
      .HYST        (HYST),
      .THR_RST_VAL (THR_RST_VAL)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .wr_en        (wr_sel),
      .wr_data      (thr_wr_data),
      .over         (over[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i])
    );
  end

`ifdef THRMON_MINMAX_EN
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  // Symmetric negative bound (-POS_MAX), not the most-negative code.
  localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_seen <= POS_MAX;
      max_seen <= NEG_MAX;
    end else if (stat_clr) begin
      min_seen <= sample_valid ? sample_data : POS_MAX;
      max_seen <= sample_valid ? sample_data : NEG_MAX;
    end else if (sample_valid) begin
      if ($signed(sample_data) < $signed(min_seen)) min_seen <= sample_data;
      if ($signed(sample_data) > $signed(max_seen)) max_seen <= sample_data;
    end
  end
`endif

endmodule

// File: tb/tb_threshold_monitor_multi.sv
module tb_threshold_monitor_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        thr_wr_en;
  logic [1:0]  thr_wr_idx;
  logic [31:0] thr_wr_data;
  logic [3:0]  over, rise_pulse, fall_pulse;
`ifdef THRMON_MINMAX_EN
  logic        stat_clr;
  logic [31:0] min_seen, max_seen;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  threshold_monitor_multi #(
    .DATA_W      (32),
    .NUM_THR     (4),
    .DEBOUNCE    (3),
    .HYST        (10),
    .THR_RST_VAL (-100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .thr_wr_en    (thr_wr_en),
    .thr_wr_idx   (thr_wr_idx),
    .thr_wr_data  (thr_wr_data),
    .over         (over),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse)
`ifdef THRMON_MINMAX_EN
    ,
    .stat_clr     (stat_clr),
    .min_seen     (min_seen),
    .max_seen     (max_seen)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one cycle of input, then return #1 after the capturing edge.
  task automatic step(input logic v, input int d);
    sample_valid = v;
    sample_data  = d;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    thr_wr_en    = 1'b0;
  endtask

  task automatic wr_step(input logic [1:0] idx, input int thr, input logic v, input int d);
    thr_wr_en   = 1'b1;
    thr_wr_idx  = idx;
    thr_wr_data = thr;
    step(v, d);
  endtask

  task automatic chk3(input string tag, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    check({tag, ".over"}, over, o);
    check({tag, ".rise"}, rise_pulse, r);
    check({tag, ".fall"}, fall_pulse, f);
  endtask

  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b0; sample_data = '0;
    thr_wr_en = 1'b0; thr_wr_idx = '0; thr_wr_data = '0;
`ifdef THRMON_MINMAX_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk3("reset", 4'b0000, 4'b0000, 4'b0000);
`ifdef THRMON_MINMAX_EN
    check("reset.min", min_seen, 32'h7fffffff);
    check("reset.max", max_seen, 32'h80000001);
`endif
    rst_n = 1'b1;

    // Park channels 2 and 3 high; ch0 and ch1 stay at -100.
    wr_step(2'd2, 1000, 1'b0, 0);
    wr_step(2'd3, 1000, 1'b0, 0);

    // Sample equal to threshold is not above.
    for (int i = 0; i < 3; i++) step(1'b1, -100);
    chk3("equal_thr", 4'b0000, 4'b0000, 4'b0000);

    // Test 1: -99 x3 asserts over on the third.
    step(1'b1, -99);
    chk3("t1.s1", 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, -99);
    chk3("t1.s2", 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, -99);
    chk3("t1.s3", 4'b0011, 4'b0011, 4'b0000);
    step(1'b0, 0);
    chk3("t1.idle", 4'b0011, 4'b0000, 4'b0000);

    // Test 3: hysteresis band holds, release level -110 drops it.
    for (int i = 0; i < 5; i++) step(1'b1, -105);
    chk3("t3.band", 4'b0011, 4'b0000, 4'b0000);
    step(1'b1, -110);
    step(1'b1, -110);
    chk3("t3.rel2", 4'b0011, 4'b0000, 4'b0000);
    step(1'b1, -110);
    chk3("t3.rel3", 4'b0000, 4'b0000, 4'b0011);
    step(1'b0, 0);
    chk3("t3.idle", 4'b0000, 4'b0000, 4'b0000);

    // Test 2: rising abort.
    step(1'b1, -99);
    step(1'b1, -99);
    step(1'b1, -101);
    chk3("t2.abort", 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, -99);
    step(1'b1, -99);
    chk3("t2.s5", 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, -99);
    chk3("t2.s6", 4'b0011, 4'b0011, 4'b0000);

    // Bring ch0/ch1 back down before the collision test.
    for (int i = 0; i < 3; i++) step(1'b1, -120);
    chk3("t4.pre", 4'b0000, 4'b0000, 4'b0011);

    // Test 4: write thr1 = -50 together with sample -60.
    wr_step(2'd1, -50, 1'b1, -60);
    chk3("t4.wr", 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, -60);
    step(1'b1, -60);
    chk3("t4.s3", 4'b0001, 4'b0001, 4'b0000);
    step(1'b1, -60);
    chk3("t4.s4", 4'b0001, 4'b0000, 4'b0000);

    // Test 5: gaps do not break debounce on ch1 (thr -50).
    step(1'b1, -40);
    for (int i = 0; i < 4; i++) step(1'b0, 0);
    step(1'b1, -40);
    chk3("t5.gap", 4'b0001, 4'b0000, 4'b0000);
    step(1'b1, -40);
    chk3("t5.rise", 4'b0011, 4'b0010, 4'b0000);
    step(1'b1, -60);
    chk3("t5.falling", 4'b0011, 4'b0000, 4'b0000);

    // Asynchronous reset mid-FALLING.
    #2 rst_n = 1'b0;
    #1;
    chk3("t5.async_rst", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 0);
    chk3("t5.post_rst", 4'b0000, 4'b0000, 4'b0000);
    // All thresholds back at -100: every channel trips.
    for (int i = 0; i < 3; i++) step(1'b1, -99);
    chk3("t5.thr_reset", 4'b1111, 4'b1111, 4'b0000);

`ifdef THRMON_MINMAX_EN
    stat_clr = 1'b1;
    step(1'b0, 0);
    stat_clr = 1'b0;
    check("t6.clr.min", min_seen, 32'h7fffffff);
    check("t6.clr.max", max_seen, 32'h80000001);
    step(1'b1, 7);
    step(1'b1, -3);
    check("t6.mid.min", min_seen, 32'hfffffffd);
    check("t6.mid.max", max_seen, 32'h00000007);
    step(1'b1, 32'h7fffffff);
    step(1'b1, 32'h80000000);
    check("t6.min", min_seen, 32'h80000000);
    check("t6.max", max_seen, 32'h7fffffff);
    stat_clr = 1'b1;
    step(1'b1, 5);
    stat_clr = 1'b0;
    check("t6.ld.min", min_seen, 32'h00000005);
    check("t6.ld.max", max_seen, 32'h00000005);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
